// File: rtl/prog_updown_counter.sv
// Parametrised modulo counter: fixed down, fixed up, runtime direction or bounce.
// Optional Gray-coded output is enabled with the PROG_CNT_GRAY_EN macro.
module prog_updown_counter #(
    parameter int N    = 8,
    parameter int MODE = 1,
    parameter int MAX  = 2**N-1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         wrap,
    output logic         dir_out
`ifdef PROG_CNT_GRAY_EN
    ,
    output logic [N-1:0] count_gray
`endif
);

    localparam logic [N-1:0] MAXV      = N'(MAX);
    localparam logic [N-1:0] RST_COUNT = (MODE == 0) ? MAXV : '0;

    logic [N-1:0] count_q, count_n;
    logic         wrap_q, wrap_n;
    logic         bdir_q, bdir_n;
    logic         up;

    // Effective direction; only bounce mode has its own direction register.
    always_comb begin
        up = 1'b1;
        case (MODE)
            0:       up = 1'b0;
            1:       up = 1'b1;
            2:       up = dir;
            default: up = bdir_q;
        endcase
    end

    always_comb begin
        count_n = count_q;
        wrap_n  = 1'b0;
        bdir_n  = bdir_q;
        if (load) begin
            count_n = (load_val > MAXV) ? MAXV : load_val;
        end else if (en) begin
            if (MODE == 3) begin
                // Bounce turns around at the ends instead of wrapping.
                if (up) begin
                    if (count_q == MAXV) begin
                        count_n = MAXV - 1'b1;
                        bdir_n  = 1'b0;
                        wrap_n  = 1'b1;
                    end else begin
                        count_n = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_n = N'(1);
                        bdir_n  = 1'b1;
                        wrap_n  = 1'b1;
                    end else begin
                        count_n = count_q - 1'b1;
                    end
                end
            end else if (up) begin
                if (count_q == MAXV) begin
                    count_n = '0;
                    wrap_n  = 1'b1;
                end else begin
                    count_n = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_n = MAXV;
                    wrap_n  = 1'b1;
                end else begin
                    count_n = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_COUNT;
            wrap_q  <= 1'b0;
            bdir_q  <= 1'b1;
        end else begin
            count_q <= count_n;
            wrap_q  <= wrap_n;
            bdir_q  <= bdir_n;
        end
    end

`ifdef PROG_CNT_GRAY_EN
    logic [N-1:0] gray_q;

    // Registered from the next count so it stays cycle-aligned and glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gray_q <= RST_COUNT ^ (RST_COUNT >> 1);
        end else begin
            gray_q <= count_n ^ (count_n >> 1);
        end
    end

    assign count_gray = gray_q;
`endif

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign dir_out = up;
    assign tc      = up ? (count_q == MAXV) : (count_q == '0);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Randomized scoreboard bench driving one counter of every MODE (N=4, MAX=9)
// in parallel against an arithmetic reference model.
module tb_prog_updown_counter;

    localparam int N   = 4;
    localparam int MAX = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         dir;
    logic         load;
    logic [N-1:0] load_val;

    logic [N-1:0] cnt [4];
    logic         tcs [4];
    logic         wrp [4];
    logic         dro [4];
`ifdef PROG_CNT_GRAY_EN
    logic [N-1:0] gry [4];
`endif

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        prog_updown_counter #(.N(N), .MODE(m), .MAX(MAX)) dut (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .dir        (dir),
            .load       (load),
            .load_val   (load_val),
            .count      (cnt[m]),
            .tc         (tcs[m]),
            .wrap       (wrp[m]),
            .dir_out    (dro[m])
`ifdef PROG_CNT_GRAY_EN
            ,
            .count_gray (gry[m])
`endif
        );
    end

    typedef struct packed {
        logic [3:0][N-1:0] cnt;
        logic [3:0]        wrp;
        logic [3:0]        up;
    } exp_t;

    exp_t expQ[$];

    int checks   = 0;
    int failures = 0;

    int mc [4];
    bit mw [4];
    bit md [4];

    task automatic checkOutput(input string name, input int m, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s mode=%0d got=%0d expected=%0d at %0t", name, m, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 4; m++) begin
            mc[m] = (m == 0) ? MAX : 0;
            mw[m] = 1'b0;
            md[m] = 1'b1;
        end
    endtask

    function automatic bit effUp(input int m);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return dir;
            default: return md[m];
        endcase
    endfunction

    // One clock edge of the reference, using the inputs present at that edge.
    task automatic modelStep();
        for (int m = 0; m < 4; m++) begin
            bit u;
            u = effUp(m);
            mw[m] = 1'b0;
            if (load) begin
                mc[m] = (int'(load_val) > MAX) ? MAX : int'(load_val);
            end else if (en) begin
                if (m == 3) begin
                    if (u && mc[m] == MAX) begin
                        mc[m] = MAX - 1; md[m] = 1'b0; mw[m] = 1'b1;
                    end else if (!u && mc[m] == 0) begin
                        mc[m] = 1; md[m] = 1'b1; mw[m] = 1'b1;
                    end else begin
                        mc[m] = u ? mc[m] + 1 : mc[m] - 1;
                    end
                end else if (u) begin
                    mc[m] = (mc[m] + 1) % (MAX + 1);
                    mw[m] = (mc[m] == 0);
                end else begin
                    mw[m] = (mc[m] == 0);
                    mc[m] = (mc[m] + MAX) % (MAX + 1);
                end
            end
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            e.cnt[m] = N'(mc[m]);
            e.wrp[m] = mw[m];
            e.up[m]  = effUp(m);
        end
        expQ.push_back(e);
    endtask

    task automatic applyStimulus();
        load     = ($urandom_range(0, 7) == 0);
        en       = ($urandom_range(0, 3) != 0);
        load_val = N'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) dir = ~dir;
    endtask

    // Monitor: compares every sampled output against the oldest expectation.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            int   ec;
            e = expQ.pop_front();
            for (int m = 0; m < 4; m++) begin
                ec = int'(e.cnt[m]);
                checkOutput("count",   m, int'(cnt[m]), ec);
                checkOutput("wrap",    m, int'(wrp[m]), int'(e.wrp[m]));
                checkOutput("dir_out", m, int'(dro[m]), int'(e.up[m]));
                checkOutput("tc",      m, int'(tcs[m]),
                            int'(e.up[m] ? (ec == MAX) : (ec == 0)));
`ifdef PROG_CNT_GRAY_EN
                checkOutput("count_gray", m, int'(gry[m]), ec ^ (ec >> 1));
`endif
            end
        end
    end

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        dir      = 1'b1;
        load     = 1'b0;
        load_val = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        pushExpected();
        rst = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                modelStep();
            end else begin
                modelReset();
                rst = 1'b1;
            end
            applyStimulus();
            if ($urandom_range(0, 49) == 0) begin
                // Reset asserted between edges must show before the next edge.
                modelReset();
                pushExpected();
                #2;
                rst = 1'b0;
            end else begin
                pushExpected();
            end
        end
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 0, expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
